// File: rtl/define.svh
// Shared datapath width for the radix-16 butterfly and its memory banks.
`ifndef DEFINE_SVH
`define DEFINE_SVH
`define D_width 16
`endif

// File: rtl/r16_out_wb.sv
// Write-back stage of the radix-16 butterfly: maps 16 results onto bank write lanes,
// buffers them in a 2-entry valid/ready FIFO and counts written beats per stage.
`include "define.svh"

module r16_out_wb #(
    parameter int ADDR_W = 10,
    parameter int BEATS  = 64,
    parameter int CNT_W  = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      LAST_STAGE,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [16*`D_width-1:0]    R16_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         mem_waddr,
    output logic [16*`D_width-1:0]    mem_wdata,
    output logic [15:0]               mem_wen,
    output logic [CNT_W-1:0]          beat_cnt,
    output logic                      done
);

    localparam int DW = `D_width;
    localparam int LW = 16 * DW;

    // The head entry lives directly in the mem_* output registers; r_tail_* is the second slot.
    logic [1:0]        r_count;
    logic [LW-1:0]     r_tail_data;
    logic [15:0]       r_tail_wen;
    logic [ADDR_W-1:0] r_tail_addr;

    logic              w_push;
    logic              w_pop;
    logic [LW-1:0]     w_map_data;
    logic [15:0]       w_map_wen;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Lane mapping at push time; the last stage keeps only y0 and y8 in lanes 0 and 1.
    always_comb begin
        w_map_data = '0;
        w_map_wen  = 16'h0000;
        if (LAST_STAGE) begin
            w_map_data[DW-1:0]    = R16_y[DW-1:0];
            w_map_data[2*DW-1:DW] = R16_y[9*DW-1:8*DW];
            w_map_wen             = 16'h0003;
        end else begin
            w_map_data = R16_y;
            w_map_wen  = 16'hFFFF;
        end
    end

    // FIFO occupancy, head (output) and tail entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 2'd0;
            mem_waddr   <= '0;
            mem_wdata   <= '0;
            mem_wen     <= 16'h0000;
            r_tail_addr <= '0;
            r_tail_data <= '0;
            r_tail_wen  <= 16'h0000;
        end else if (clear) begin
            r_count <= 2'd0;
            mem_wen <= 16'h0000;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        mem_waddr <= in_addr;
                        mem_wdata <= w_map_data;
                        mem_wen   <= w_map_wen;
                        r_count   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        mem_waddr <= in_addr;
                        mem_wdata <= w_map_data;
                        mem_wen   <= w_map_wen;
                    end else if (w_push) begin
                        r_tail_addr <= in_addr;
                        r_tail_data <= w_map_data;
                        r_tail_wen  <= w_map_wen;
                        r_count     <= 2'd2;
                    end else if (w_pop) begin
                        // Data and address hold; only the enables drop when empty.
                        mem_wen <= 16'h0000;
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        mem_waddr <= r_tail_addr;
                        mem_wdata <= r_tail_data;
                        mem_wen   <= r_tail_wen;
                        r_count   <= 2'd1;
                    end
                end
                default: begin
                    mem_wen <= 16'h0000;
                    r_count <= 2'd0;
                end
            endcase
        end
    end

    // Beat counter with wrap at BEATS and a one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            done     <= 1'b0;
        end else if (clear) begin
            beat_cnt <= '0;
            done     <= 1'b0;
        end else if (w_pop) begin
            if (beat_cnt == CNT_W'(BEATS - 1)) begin
                beat_cnt <= '0;
                done     <= 1'b1;
            end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                done     <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_r16_out_wb.sv
// Directed self-checking bench for r16_out_wb (BEATS=4 so stage wrap is reachable quickly).
`ifndef D_width
`define D_width 16
`endif

module tb_r16_out_wb;

    localparam int DW     = `D_width;
    localparam int LW     = 16 * DW;
    localparam int ADDR_W = 10;
    localparam int BEATS  = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              LAST_STAGE;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [LW-1:0]     R16_y;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] mem_waddr;
    logic [LW-1:0]     mem_wdata;
    logic [15:0]       mem_wen;
    logic [CNT_W-1:0]  beat_cnt;
    logic              done;

    int checks   = 0;
    int failures = 0;

    r16_out_wb #(.ADDR_W(ADDR_W), .BEATS(BEATS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .LAST_STAGE(LAST_STAGE),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .R16_y(R16_y),
        .out_valid(out_valid), .out_ready(out_ready), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wen(mem_wen), .beat_cnt(beat_cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic set_y_seq();
        for (int i = 0; i < 16; i++) R16_y[i*DW +: DW] = DW'(i + 1);
    endtask

    task automatic set_y_compact();
        for (int i = 0; i < 16; i++) R16_y[i*DW +: DW] = DW'(8'hFF);
        R16_y[0 +: DW]    = DW'(8'hAA);
        R16_y[8*DW +: DW] = DW'(8'hBB);
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic push_one(input logic ls, input logic [ADDR_W-1:0] a);
        LAST_STAGE = ls;
        in_addr    = a;
        in_valid   = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (mem_wen !== 16'h0000) begin failures++; $display("FAIL reset_wen got=%h exp=0000", mem_wen); end
        checks++; if (mem_waddr !== '0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", mem_waddr); end
        checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
        checks++; if (beat_cnt !== '0 || done !== 1'b0) begin failures++; $display("FAIL reset_cnt got=%0d/%0b exp=0/0", beat_cnt, done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [LW-1:0] exp_d;
        for (int i = 0; i < 16; i++) exp_d[i*DW +: DW] = DW'(i + 1);
        out_ready = 1'b1;
        set_y_seq();
        push_one(1'b0, 10'd5);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
        checks++; if (mem_waddr !== 10'd5) begin failures++; $display("FAIL basic_addr got=%0d exp=5", mem_waddr); end
        checks++; if (mem_wdata !== exp_d) begin failures++; $display("FAIL basic_data got=%h exp=%h", mem_wdata, exp_d); end
        checks++; if (mem_wen !== 16'hFFFF) begin failures++; $display("FAIL basic_wen got=%h exp=ffff", mem_wen); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || mem_wen !== 16'h0000) begin failures++; $display("FAIL basic_empty got=%0b/%h exp=0/0000", out_valid, mem_wen); end
        checks++; if (beat_cnt !== 3'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", beat_cnt); end
    endtask

    task automatic test_compact();
        logic [LW-1:0] exp_d;
        exp_d = '0;
        exp_d[0 +: DW]  = DW'(8'hAA);
        exp_d[DW +: DW] = DW'(8'hBB);
        set_y_compact();
        push_one(1'b1, 10'd3);
        in_valid = 1'b0;
        checks++; if (mem_wdata !== exp_d) begin failures++; $display("FAIL compact_data got=%h exp=%h", mem_wdata, exp_d); end
        checks++; if (mem_wen !== 16'h0003) begin failures++; $display("FAIL compact_wen got=%h exp=0003", mem_wen); end
        checks++; if (mem_waddr !== 10'd3) begin failures++; $display("FAIL compact_addr got=%0d exp=3", mem_waddr); end
        @(negedge clk);
        checks++; if (beat_cnt !== 3'd2) begin failures++; $display("FAIL compact_cnt got=%0d exp=2", beat_cnt); end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] got [8];
        int   n;
        logic acc;
        do_clear();
        set_y_seq();
        out_ready = 1'b0;
        push_one(1'b0, 10'd1);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0b exp=1", in_ready); end
        push_one(1'b0, 10'd2);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%0b exp=0", in_ready); end
        in_addr = 10'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (mem_waddr !== 10'd1 || out_valid !== 1'b1 || in_ready !== 1'b0 || mem_wen !== 16'hFFFF) begin
                failures++;
                $display("FAIL bp_stall addr=%0d valid=%0b ready=%0b wen=%h exp=1/1/0/ffff", mem_waddr, out_valid, in_ready, mem_wen);
            end
        end
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid && n < 8) begin got[n] = mem_waddr; n++; end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) in_valid = 1'b0;
        end
        checks++; if (n !== 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", n); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k < n && got[k] !== ADDR_W'(k + 1)) begin failures++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", k, got[k], k + 1); end
        end
        checks++; if (beat_cnt !== 3'd3) begin failures++; $display("FAIL bp_cnt got=%0d exp=3", beat_cnt); end
    endtask

    task automatic test_stream();
        logic [CNT_W-1:0] exp_cnt [7];
        logic             exp_done[7];
        exp_cnt  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd1};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_clear();
        out_ready  = 1'b1;
        LAST_STAGE = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k < 5) begin in_valid = 1'b1; in_addr = ADDR_W'(10 + k); end
            else in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (beat_cnt !== exp_cnt[k] || done !== exp_done[k]) begin
                failures++;
                $display("FAIL stream_cnt step=%0d got=%0d/%0b exp=%0d/%0b", k, beat_cnt, done, exp_cnt[k], exp_done[k]);
            end
            checks++;
            if (k < 5 && (out_valid !== 1'b1 || mem_waddr !== ADDR_W'(10 + k))) begin
                failures++;
                $display("FAIL stream_head step=%0d got=%0b/%0d exp=1/%0d", k, out_valid, mem_waddr, 10 + k);
            end else if (k >= 5 && out_valid !== 1'b0) begin
                failures++;
                $display("FAIL stream_empty step=%0d got=%0b exp=0", k, out_valid);
            end
        end
    endtask

    task automatic test_mode_toggle();
        do_clear();
        out_ready = 1'b0;
        set_y_seq();
        push_one(1'b0, 10'd20);
        set_y_compact();
        push_one(1'b1, 10'd21);
        in_valid   = 1'b0;
        LAST_STAGE = 1'b0;
        checks++; if (mem_wen !== 16'hFFFF || mem_waddr !== 10'd20) begin failures++; $display("FAIL toggle_first got=%h/%0d exp=ffff/20", mem_wen, mem_waddr); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (mem_wen !== 16'h0003 || mem_waddr !== 10'd21) begin failures++; $display("FAIL toggle_second got=%h/%0d exp=0003/21", mem_wen, mem_waddr); end
        checks++; if (mem_wdata[2*DW-1:0] !== {DW'(8'hBB), DW'(8'hAA)}) begin failures++; $display("FAIL toggle_data got=%h exp=bb/aa", mem_wdata[2*DW-1:0]); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || mem_wen !== 16'h0000) begin failures++; $display("FAIL toggle_empty got=%0b/%h exp=0/0000", out_valid, mem_wen); end
    endtask

    task automatic fill_two_cnt_two();
        do_clear();
        out_ready = 1'b1;
        set_y_seq();
        push_one(1'b0, 10'd40);
        push_one(1'b0, 10'd41);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        push_one(1'b0, 10'd42);
        push_one(1'b0, 10'd43);
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        fill_two_cnt_two();
        checks++; if (beat_cnt !== 3'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL arst_setup got=%0d/%0b exp=2/0", beat_cnt, in_ready); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL arst_hs got=%0b/%0b exp=1/0", in_ready, out_valid); end
        checks++; if (mem_wen !== 16'h0000 || mem_waddr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL arst_out got=%h/%0d exp=0000/0", mem_wen, mem_waddr); end
        checks++; if (beat_cnt !== '0 || done !== 1'b0) begin failures++; $display("FAIL arst_cnt got=%0d/%0b exp=0/0", beat_cnt, done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clear();
        fill_two_cnt_two();
        clear     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_wen !== 16'h0000) begin failures++; $display("FAIL clear_buf got=%0b/%0b/%h exp=0/1/0000", out_valid, in_ready, mem_wen); end
        checks++; if (beat_cnt !== '0 || done !== 1'b0) begin failures++; $display("FAIL clear_cnt got=%0d/%0b exp=0/0", beat_cnt, done); end
        // clear with a push: in_ready stays high but the beat is dropped
        clear    = 1'b1;
        in_valid = 1'b1;
        in_addr  = 10'd50;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clear_push_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL clear_push_drop got=%0b/%0b exp=0/0", out_valid, done); end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; LAST_STAGE = 1'b0; in_valid = 1'b0;
        in_addr = '0; R16_y = '0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_compact();
        test_backpressure();
        test_stream();
        test_mode_toggle();
        test_async_reset();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/r16_out_wb.md
Name: r16_out_wb

Overview:
- Write-back side of the radix-16 butterfly datapath: captures the 16 butterfly results plus their bank address and returns them to the memory write ports.
- Provides a 2-entry valid/ready buffer, per-beat LAST_STAGE lane compaction, a per-lane write-enable mask, and a beat counter that pulses done at the end of each stage.
- Sits between the R16 butterfly output and the memory bank write interface, mirroring the input-side mux/twiddle selection.

Parameters:
- ADDR_W, 10, bank address width.
- BEATS, 64, number of write beats per stage; done pulses after the BEATS-th accepted write. Legal range 1..2^CNT_W.
- CNT_W, 7, beat counter width, at least clog2(BEATS+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: empties buffer, zeroes beat counter
- LAST_STAGE  in  1  sampled with each input beat; selects compaction mode for that beat
- in_valid  in  1  butterfly results valid
- in_ready  out  1  buffer can accept a beat
- in_addr  in  ADDR_W  bank address for the beat
- R16_y  in  16*`D_width  butterfly outputs, y0 in LSBs, y15 in MSBs
- out_valid  out  1  write beat valid
- out_ready  in  1  memory accepts the write
- mem_waddr  out  ADDR_W  write address
- mem_wdata  out  16*`D_width  write data, lane 0 in LSBs
- mem_wen  out  16  per-lane write enable
- beat_cnt  out  CNT_W  accepted writes in the current stage
- done  out  1  one-cycle pulse at stage end

Behaviour:
- Data width is `D_width from define.svh.
- Single clock domain. Reset is asynchronous and active-low on rst_n. All flops use async reset.
- Reset values: in_ready=1, out_valid=0, mem_waddr=0, mem_wdata=0, mem_wen=0, beat_cnt=0, done=0, buffer empty.
- Handshakes:
  - Input push occurs on in_valid && in_ready.
  - Output pop occurs on out_valid && out_ready.
  - in_valid and its payload must be held until accepted.
- Buffer:
  - 2-entry FIFO; each entry holds the mapped data, wen and addr.
  - Mapping is applied at push time, so outputs are driven straight from head-entry registers.
  - in_ready = (count<2). It is registered-equivalent and does not depend combinationally on out_ready.
  - out_valid = (count>0).
  - Latency: a beat pushed in cycle N appears on the outputs in cycle N+1 when the FIFO was empty.
  - Simultaneous push and pop: count is unchanged and ordering is preserved. Push is impossible when count=2. Pop from count=1 with a push leaves the new beat at the head next cycle.
  - Head outputs hold stable while out_valid && !out_ready.
  - When empty, mem_wen=0. mem_wdata and mem_waddr hold their last values and are don't-care.
- Lane mapping, LAST_STAGE=0: lane i = y_i for i=0..15, wen=16'hFFFF, addr=in_addr.
- Lane mapping, LAST_STAGE=1: lane0=y0, lane1=y8, lanes 2..15=0, wen=16'h0003, addr=in_addr. This is the inverse of the input-side placement (mem_x0 to x0, mem_x1 to x8).
- LAST_STAGE is captured per beat. Toggling it while the buffer holds beats does not alter buffered beats.
- Beat counter:
  - Increments on each pop.
  - On the pop that makes the count equal BEATS, beat_cnt wraps to 0 and done=1 in the following cycle, for exactly one cycle.
- clear:
  - Next cycle: buffer empty, beat_cnt=0, done=0, in_ready=1. Any in-flight beats are dropped.
  - If clear and a push occur in the same cycle, clear wins and the push is dropped; in_ready is still 1 that cycle.
  - If clear and a pop occur in the same cycle, the pop is not counted and done is not pulsed.
- Reset mid-operation: immediate return to reset values regardless of handshake state. A beat presented during reset is lost.
- No combinational path from in_valid or R16_y to any output.

Test Plan:
- Reset, then push one beat: LAST_STAGE=0, in_addr=5, y_i=i+1, out_ready=1 -> next cycle out_valid=1, mem_waddr=5, lane i=i+1, mem_wen=16'hFFFF; one cycle later out_valid=0, beat_cnt=1.
- LAST_STAGE=1, y0=0xAA, y8=0xBB, all other y=0xFF, in_addr=3 -> lane0=0xAA, lane1=0xBB, lanes 2..15=0, mem_wen=16'h0003, mem_waddr=3.
- Backpressure: out_ready=0, push addrs 1,2,3 -> in_ready drops after 2 pushes; addr 3 stalls with outputs stable at addr 1. Raise out_ready -> writes 1,2,3 in order with no loss or duplication.
- Full-throughput streaming with BEATS=4, continuous valid/ready, 4 beats -> beat_cnt 1,2,3,0; done high for exactly one cycle after the 4th pop; the 5th beat counts as 1.
- Mode toggle: buffer one LAST_STAGE=0 beat with out_ready=0, then push a LAST_STAGE=1 beat -> first write wen=16'hFFFF, second wen=16'h0003.
- Async rst_n pulse with 2 beats buffered and beat_cnt=2 mid-cycle -> outputs immediately at reset values. Repeat with clear in place of reset: empty FIFO and beat_cnt=0 the next cycle, no done pulse.
